// File: rtl/y_arith_pkg.sv
// Shared constants for the y_arith adder/subtractor: default datapath width
// and the encoding of the add/subtract control bit.
package y_arith_pkg;

    localparam int   Y_ARITH_WIDTH = 32;
    localparam logic CTRL_ADD      = 1'b0;
    localparam logic CTRL_SUB      = 1'b1;

endpackage : y_arith_pkg

// File: rtl/y_adder1.sv
// One-bit full adder; one stage of the y_arith ripple-carry chain.
module y_adder1 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic z,
    output logic cout
);

    assign z    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : y_adder1

// File: rtl/y_arith.sv
// Registered two's-complement adder/subtractor built on a y_adder1 ripple chain.
// Define Y_ARITH_OVERFLOW_EN to add the registered signed-overflow output ovf.
module y_arith
    import y_arith_pkg::*;
#(
    parameter int WIDTH = Y_ARITH_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] z,
`ifdef Y_ARITH_OVERFLOW_EN
    output logic             ovf,
`endif
    output logic             cout
);

    logic [WIDTH-1:0] bb;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    // Subtraction is a + ~b + 1: invert the B path and inject the 1 as carry-in.
    assign bb       = (ctrl == CTRL_SUB) ? ~b : b;
    assign carry[0] = (ctrl == CTRL_SUB);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        y_adder1 u_bit (
            .a    (a[i]),
            .b    (bb[i]),
            .cin  (carry[i]),
            .z    (sum[i]),
            .cout (carry[i+1])
        );
    end

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            z         <= '0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                z    <= sum;
                cout <= carry[WIDTH];
            end
        end
    end

`ifdef Y_ARITH_OVERFLOW_EN
    // Signed overflow: operands agree in sign but the result does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (in_valid) begin
            ovf <= (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
    end
`endif

endmodule : y_arith

// File: tb/tb_y_arith.sv
// Self-checking bench for y_arith: directed corner cases, back-to-back random
// vectors against an arithmetic reference model, hold and async reset checks.
module tb_y_arith;

    localparam int W = 32;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         in_valid = 1'b0;
    logic         ctrl     = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic [W-1:0] z;
    logic         cout;
    logic         out_valid;
`ifdef Y_ARITH_OVERFLOW_EN
    logic         ovf;
`endif

    int tests_run = 0;
    int failed    = 0;

    always #5 clk = ~clk;

    y_arith dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .z         (z),
`ifdef Y_ARITH_OVERFLOW_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

    task automatic check_word(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic check_bit(input string tag, input logic observed, input logic expected);
        tests_run++;
        assert (observed === expected) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // Reference model: plain unsigned/signed arithmetic on the operands.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                                  output logic [W-1:0] rz, output logic rc, output logic rovf);
        longint sx   = longint'($signed(x));
        longint sy   = longint'($signed(y));
        longint smax = (longint'(1) <<< (W - 1)) - 1;
        longint smin = -(longint'(1) <<< (W - 1));
        longint sres;
        if (op) begin
            rz   = x - y;
            rc   = (x >= y);
            sres = sx - sy;
        end else begin
            {rc, rz} = {1'b0, x} + {1'b0, y};
            sres     = sx + sy;
        end
        rovf = (sres > smax) || (sres < smin);
    endfunction

    // Drive one valid operation, then check the registered result after the edge.
    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic op,
                         input string tag);
        logic [W-1:0] ez;
        logic         ec;
        logic         eo;
        @(negedge clk);
        a        = x;
        b        = y;
        ctrl     = op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        model(x, y, op, ez, ec, eo);
        check_bit({tag, "_valid"}, out_valid, 1'b1);
        check_word({tag, "_z"}, z, ez);
        check_bit({tag, "_cout"}, cout, ec);
`ifdef Y_ARITH_OVERFLOW_EN
        check_bit({tag, "_ovf"}, ovf, eo);
`endif
    endtask

    initial begin
        logic [W-1:0] held_z;
        logic         held_c;

        // Power-on reset: outputs are zero before any clock edge.
        #1;
        check_bit("rst_valid", out_valid, 1'b0);
        check_word("rst_z", z, '0);
        check_bit("rst_cout", cout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed corner cases, each also pinned to a literal expectation.
        apply(32'd5, 32'd3, 1'b0, "add_5_3");
        check_word("add_5_3_lit", z, 32'd8);
        check_bit("add_5_3_lit_c", cout, 1'b0);
        apply(32'd5, 32'd3, 1'b1, "sub_5_3");
        check_word("sub_5_3_lit", z, 32'd2);
        check_bit("sub_5_3_lit_c", cout, 1'b1);
        apply(32'd3, 32'd5, 1'b1, "sub_3_5");
        check_word("sub_3_5_lit", z, 32'hFFFF_FFFE);
        check_bit("sub_3_5_lit_c", cout, 1'b0);
        apply(32'hFFFF_FFFF, 32'd1, 1'b0, "wrap");
        check_word("wrap_lit", z, 32'd0);
        check_bit("wrap_lit_c", cout, 1'b1);
        apply(32'h7FFF_FFFF, 32'd1, 1'b0, "sovf");
        check_word("sovf_lit", z, 32'h8000_0000);
        check_bit("sovf_lit_c", cout, 1'b0);
`ifdef Y_ARITH_OVERFLOW_EN
        check_bit("sovf_lit_ovf", ovf, 1'b1);
`endif

        // Back-to-back random regression.
        for (int i = 0; i < 16; i++) begin
            apply($urandom, $urandom, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
        end

        // Drop in_valid for one cycle: out_valid falls, result holds.
        held_z = z;
        held_c = cout;
        @(negedge clk);
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        ctrl     = ~ctrl;
        @(posedge clk);
        #1;
        check_bit("idle_valid", out_valid, 1'b0);
        check_word("idle_hold_z", z, held_z);
        check_bit("idle_hold_cout", cout, held_c);

        // Async reset between edges while a valid result is present.
        apply(32'h1234_5678, 32'h1111_1111, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_valid", out_valid, 1'b0);
        check_word("arst_z", z, '0);
        check_bit("arst_cout", cout, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        apply(32'd10, 32'd4, 1'b1, "post_rst");
        check_word("post_rst_lit", z, 32'd6);

        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule : tb_y_arith

// File: doc/y_arith.md
# y_arith

Registered two's-complement 32-bit adder/subtractor: computes `a + b` or `a - b` under a single control bit and returns the sum with carry-out. It is the arithmetic core of the lab datapath ALU, used by the ALU and address-increment logic. The core is built as a ripple-carry chain of 1-bit full adders, with operands captured and the result registered on one clock.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; must be 2 or more.

Ports:
- `clk`  input  1: the block's single clock; all state changes on the rising edge.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `in_valid`  input  1: qualifies `a`, `b` and `ctrl` in the current cycle.
- `a`  input  WIDTH: operand A, two's complement.
- `b`  input  WIDTH: operand B, two's complement.
- `ctrl`  input  1: operation select; 0 = add (`a + b`), 1 = subtract (`a - b`).
- `out_valid`  output  1: `z` and `cout` hold a new result.
- `z`  output  WIDTH: result, modulo 2^WIDTH.
- `cout`  output  1: carry out of the MSB.

## Operation
- B-path operand: `bb = ctrl ? ~b : b`.
- Carry-in: `cin = ctrl`.
- Sum: `{cout, z} = a + bb + cin`, computed by a WIDTH-stage ripple chain of full adders.
- Subtraction therefore equals `a + ~b + 1`.
  - `cout` = 1 means no borrow (`a >= b` unsigned).
  - `cout` = 0 means a borrow occurred.
- Overflow beyond WIDTH wraps silently into `z`; signed overflow is flagged only under the Configuration option.
- When `in_valid` is 0:
  - `z` and `cout` hold their previous values.
  - `out_valid` goes to 0 on the next edge.
- `ctrl` is only sampled when `in_valid` = 1. An X on `ctrl` while `in_valid` = 1 is a caller error, and the output value is then undefined.

## Timing
- Latency is 1 cycle. Operands sampled at edge N produce `z`, `cout` and `out_valid` = 1 after edge N.
- Throughput is one operation per cycle with no back-pressure.
- Back-to-back valid inputs give back-to-back valid outputs.
- Reset values (`rst_n` = 0): `z` = 0, `cout` = 0, `out_valid` = 0. These apply immediately, independent of `clk`.
- Reset asserted mid-operation discards the in-flight result. The first edge after `rst_n` deasserts samples inputs normally.
- The combinational path from the input registers-in to the output registers is the full ripple chain; WIDTH = 32 must close timing at the lab clock.

## Configuration
- `Y_ARITH_OVERFLOW_EN` defined:
  - Adds output port `ovf` (1 bit), registered alongside `z` with reset value 0.
  - `ovf = (a[MSB] == bb[MSB]) && (z[MSB] != a[MSB])`, i.e. carry into the MSB XOR carry out of the MSB.
- `Y_ARITH_OVERFLOW_EN` undefined: the `ovf` port and its logic are absent, and all other behaviour is unchanged.

## Structure
- Package `y_arith_pkg` holds:
  - `Y_ARITH_WIDTH = 32`.
  - Control encodings `CTRL_ADD = 1'b0` and `CTRL_SUB = 1'b1`.
- Sub-module `y_adder1` is a 1-bit full adder.
  - Inputs `a`, `b`, `cin`; outputs `z`, `cout`.
  - `z = a ^ b ^ cin`; `cout = (a & b) | (cin & (a ^ b))`.
  - Instantiated WIDTH times by a generate loop, with the carry chained LSB to MSB.
- `y_arith` contains the B-path inversion muxes, the adder chain and the output registers.

## Test plan
- Add, no carry: `a = 5`, `b = 3`, `ctrl = 0` → one cycle later `z = 8`, `cout = 0`, `out_valid = 1`.
- Subtract, no borrow: `a = 5`, `b = 3`, `ctrl = 1` → `z = 2`, `cout = 1`.
- Subtract with borrow: `a = 3`, `b = 5`, `ctrl = 1` → `z = 0xFFFFFFFE` (-2), `cout = 0`.
- Unsigned wrap and signed overflow:
  - `a = 0xFFFFFFFF`, `b = 1`, add → `z = 0`, `cout = 1`.
  - `a = 0x7FFFFFFF`, `b = 1`, add → `z = 0x80000000`, `cout = 0`, `ovf = 1` (macro on).
- Random regression: 10 or more vectors of random `a` and `b` with `ctrl` random in {0, 1}, issued back-to-back.
  - Each result must exactly match `ctrl ? a - b : a + b` one cycle later (no X/Z).
  - `in_valid` is dropped for one cycle, after which `out_valid` must fall and `z` must hold.
- Reset: assert `rst_n = 0` between clock edges while a valid result is pending → `z = 0`, `cout = 0`, `out_valid = 0` immediately. After release, `a = 10`, `b = 4`, `ctrl = 1` → `z = 6`.
